// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg: shared state type and sizing helpers for serial_adder.
// Rev 1.0
// ============================================================================
package adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_state_type;

  function automatic int digit_count(input int width, input int digit_width);
    return width / digit_width;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int counter_width(input int width, input int digit_width);
    int n;
    n = $clog2(width / digit_width);
    return (n < 1) ? 1 : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder: one-bit full adder cell.
// Rev 1.0
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/ripple_digit_adder.sv
`default_nettype none
// ============================================================================
// ripple_digit_adder: combinational DIGIT_WIDTH-bit ripple-carry adder.
// Rev 1.0
// ============================================================================
module ripple_digit_adder #(
  parameter int DIGIT_WIDTH = 4
) (
  input  logic [DIGIT_WIDTH-1:0] augend,
  input  logic [DIGIT_WIDTH-1:0] addend,
  input  logic                   carry_in,
  output logic [DIGIT_WIDTH-1:0] sum,
  output logic                   carry_out,
  output logic                   msb_carry_in
);

  logic [DIGIT_WIDTH:0] carry;

  assign carry[0] = carry_in;

  generate
    for (genvar i = 0; i < DIGIT_WIDTH; i++) begin : g_bit
      full_adder u_fa (
        .a         (augend[i]),
        .b         (addend[i]),
        .carry_in  (carry[i]),
        .sum       (sum[i]),
        .carry_out (carry[i+1])
      );
    end
  endgenerate

  assign carry_out    = carry[DIGIT_WIDTH];
  assign msb_carry_in = carry[DIGIT_WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder: digit-serial WIDTH-bit adder with valid/ready handshakes.
// Rev 1.0
// ============================================================================
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int DIGIT_COUNT = digit_count(WIDTH, DIGIT_WIDTH);
  localparam int CNT_W       = counter_width(WIDTH, DIGIT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGIT_COUNT - 1);

  generate
    if (DIGIT_WIDTH < 1 || DIGIT_WIDTH > WIDTH || (WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT_WIDTH");
    end
  endgenerate

  adder_state_type                          state;
  logic [CNT_W-1:0]                         counter;
  logic                                     carry_reg;
  logic [WIDTH-1:0]                         aug_reg;
  logic [WIDTH-1:0]                         add_reg;
  logic [DIGIT_COUNT-1:0][DIGIT_WIDTH-1:0]  work_sum;
  logic [DIGIT_COUNT-1:0][DIGIT_WIDTH-1:0]  final_sum;
  logic [DIGIT_WIDTH-1:0]                   digit_sum;
  logic                                     digit_carry;
  logic                                     digit_msb_carry;
  logic                                     accept;

  // Operand registers shift right each step, so the low digit is always current.
  ripple_digit_adder #(.DIGIT_WIDTH(DIGIT_WIDTH)) u_digit (
    .augend       (aug_reg[DIGIT_WIDTH-1:0]),
    .addend       (add_reg[DIGIT_WIDTH-1:0]),
    .carry_in     (carry_reg),
    .sum          (digit_sum),
    .carry_out    (digit_carry),
    .msb_carry_in (digit_msb_carry)
  );

  assign start_ready  = (state == IDLE) || (state == DONE && result_ready);
  assign accept       = start_valid && start_ready;
  assign result_valid = (state == DONE);
  assign busy         = (state == BUSY);

  always_comb begin
    final_sum                = work_sum;
    final_sum[DIGIT_COUNT-1] = digit_sum;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      carry_reg <= 1'b0;
      aug_reg   <= '0;
      add_reg   <= '0;
      work_sum  <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      aug_reg   <= augend;
      add_reg   <= addend;
      carry_reg <= carry_in;
      counter   <= '0;
      state     <= BUSY;
    end else begin
      case (state)
        BUSY: begin
          aug_reg           <= aug_reg >> DIGIT_WIDTH;
          add_reg           <= add_reg >> DIGIT_WIDTH;
          carry_reg         <= digit_carry;
          work_sum[counter] <= digit_sum;
          counter           <= counter + 1'b1;
          if (counter == LAST_DIGIT) begin
            sum       <= final_sum;
            carry_out <= digit_carry;
            overflow  <= digit_carry ^ digit_msb_carry;
            state     <= DONE;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised successor to the combinational half/full adder cells.
- Adds two WIDTH-bit operands plus carry-in, DIGIT_WIDTH bits per clock, through one ripple digit adder and a registered carry.
- Valid/ready handshakes on both the operand side and the result side.
- Used where a wide adder must be area-cheap and a latency of several cycles is acceptable, e.g. accumulators and checksum datapaths.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a positive multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 4: bits added per clock cycle. Must satisfy 1 <= DIGIT_WIDTH <= WIDTH.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  operands and carry_in are presented.
- start_ready  output  1  block can accept operands this cycle.
- augend  input  WIDTH  first operand, unsigned or two's complement.
- addend  input  WIDTH  second operand.
- carry_in  input  1  carry into bit 0.
- result_valid  output  1  sum, carry_out and overflow hold a completed result.
- result_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  augend + addend + carry_in, modulo 2^WIDTH.
- carry_out  output  1  unsigned carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into the MSB XOR carry_out.
- busy  output  1  high while digits are being added.

Behaviour:
- DIGIT_COUNT = WIDTH/DIGIT_WIDTH. A parameter check at elaboration rejects a WIDTH that is not a multiple of DIGIT_WIDTH.
- State machine states: IDLE, BUSY, DONE.
- Reset (synchronous): state goes to IDLE; digit counter, carry register, operand registers, sum, carry_out and overflow go to 0; result_valid=0, busy=0, start_ready=1.
- start_ready = (state==IDLE) OR (state==DONE AND result_ready).
- Accept: start_valid AND start_ready at an edge.
  - Registers augend, addend and carry_in.
  - Clears the digit counter.
  - Next state is BUSY.
- Operand inputs are ignored outside an accept edge. Changes during BUSY/DONE have no effect.
- BUSY, each edge:
  - Adds digit[counter] of both operand registers with the carry register.
  - Writes the result digit into the working sum register and updates the carry register.
  - Increments the counter.
  - Digit 0 is the least significant.
- On the edge that processes digit DIGIT_COUNT-1:
  - Loads sum, carry_out and overflow from the working registers and the final digit's carries.
  - Next state is DONE.
- Latency: result_valid rises exactly DIGIT_COUNT edges after the accept edge. With DIGIT_COUNT=1: one edge, with BUSY lasting one cycle.
- DONE: result_valid=1. sum, carry_out and overflow hold stable until result_ready=1.
  - result_ready=1 and no new accept: next state is IDLE.
  - result_ready=1 with start_valid=1 in the same cycle: back-to-back accept, next state is BUSY with no IDLE bubble.
- sum, carry_out and overflow change only on the BUSY→DONE edge or on reset; they keep their last value in IDLE.
- busy = (state==BUSY).
- Reset mid-BUSY or mid-DONE aborts the operation:
  - No result_valid is produced for it.
  - Outputs take their reset values on that edge.
- result_ready while not in DONE is ignored.

Decomposition:
- Package adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_state_type;
  - the function that computes DIGIT_COUNT and counter width, i.e. $clog2 of DIGIT_COUNT, minimum 1.
- Sub-module ripple_digit_adder: combinational, parameter DIGIT_WIDTH.
  - Inputs: augend, addend, carry_in.
  - Outputs: sum, carry_out, and msb_carry_in for overflow.
  - Built as a chain of full_adder instances.

Test Plan (WIDTH=16, DIGIT_WIDTH=4 unless stated):
- 0x0000+0x0000, carry_in=0 → sum=0x0000, carry_out=0, overflow=0; result_valid exactly 4 edges after accept; busy high for 4 cycles.
- 0xFFFF+0x0001, carry_in=0 → sum=0x0000, carry_out=1, overflow=0 (carry crosses all digits). Also 0x1234+0x4321, carry_in=1 → sum=0x5556, carry_out=0.
- 0x7FFF+0x0001 → sum=0x8000, carry_out=0, overflow=1. Also 0x8000+0x8000 → sum=0x0000, carry_out=1, overflow=1.
- Backpressure: hold result_ready=0 for 3 cycles in DONE → outputs stable, start_ready=0. Then result_ready=1 with start_valid=1 carrying 0x0001+0x0002 → accepted that edge; sum=0x0003 four edges later.
- Assert reset for one cycle after digit 2 of 0xFFFF+0x0001 → next cycle state IDLE, result_valid=0, sum=0, start_ready=1; no result ever appears for that operation.
- Config WIDTH=8, DIGIT_WIDTH=8: 0xFF+0x01 → sum=0x00, carry_out=1, result_valid one edge after accept. Run an exhaustive random comparison against the + operator in all configs.
